rx_symbol_slicer: RTL and testbench
===================================

// Module: rx_symbol_slicer
// PURPOSE
//  Consumes the 16-bit Q2.13 matched-filter output stream (one sample per clk).
//  Discards the combined TX+RX filter transient, decimates by SPS at a fixed
//  phase, hard-slices each symbol (sign -> bit) and packs bits MSB-first into
//  bytes. Bytes are handed to the framer/UART stage over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH    16  width of signed input sample (Q2.13)
//  SPS           4   samples per symbol (decimation factor)
//  SKIP          32  input samples discarded after reset (filter group delay)
//  PHASE         0   sample index within symbol that is kept, 0..SPS-1
//  WORD_BITS     8   bits packed per output word
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           synchronous, active-high
//  in_valid   in   1           sample_in qualifier (tie 1 behind matched filter)
//  sample_in  in   DATA_WIDTH  signed matched-filter output
//  sym_strobe out  1           1-cycle pulse when a symbol is sliced
//  sym_value  out  DATA_WIDTH  soft value of the last sliced symbol
//  out_data   out  WORD_BITS   packed bits, first received bit in MSB
//  out_valid  out  1           out_data holds an unread word
//  out_ready  in   1           consumer accepts word when out_valid&&out_ready
//  overflow   out  1           sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (sync, active-high, overrides all): state=ALIGN, skip_cnt=0, phase_cnt=0,
//   bit_cnt=0, shift=0; sym_strobe=0, sym_value=0, out_data=0, out_valid=0,
//   overflow=0. Mid-operation reset discards partial and held words.
//  Only cycles with in_valid=1 advance any counter; in_valid=0 freezes state.
//  FSM ALIGN: count accepted samples; on SKIPth sample (skip_cnt==SKIP-1) go
//   SAMPLE with phase_cnt=0. ALIGN samples are never sliced. SKIP=0 -> start in SAMPLE.
//  FSM SAMPLE: phase_cnt counts 0..SPS-1, wraps to 0. When phase_cnt==PHASE on an
//   accepted sample: sym_value<=sample_in, sym_strobe<=1 next cycle (1-cycle pulse),
//   bit = ~sample_in[DATA_WIDTH-1] (>=0 -> 1, <0 -> 0), shift<={shift,bit}.
//  Zero sample slices to 1. No arithmetic on value beyond sign; no saturation.
//  bit_cnt counts 0..WORD_BITS-1; on slice with bit_cnt==WORD_BITS-1 the word
//   {shift[WORD_BITS-2:0],bit} completes and bit_cnt wraps to 0.
//  Latency: completing sample accepted at edge N -> out_valid=1 after edge N
//   (registered, same edge as sym_strobe rising).
//  Holding register (1 entry): out_data/out_valid stable while out_valid&&!out_ready.
//  Handshake: transfer on edge where out_valid&&out_ready; out_valid clears next
//   cycle unless a new word completes on the same edge.
//  Simultaneous transfer + completion: new word loaded, out_valid stays 1, no overflow.
//  Completion while out_valid&&!out_ready: new word dropped, held word kept,
//   overflow<=1 (sticky until reset). Packing continues normally.
//  out_ready while out_valid=0: ignored.
// TESTING
//  1 Reset 3 cycles, sample_in=+0x2000 constant, out_ready=1 -> no sym_strobe
//    for first 32 samples; then strobe every 4 clks; every 32 clks out_data=0xFF.
//  2 Symbols +0x2000/-0x2000 alternating starting with +, each held 4 samples,
//    PHASE=0 -> out_data=0xAA repeatedly; sym_value toggles 0x2000/0xE000.
//  3 sample_in=0x0000 after skip -> every bit 1 (zero slices high), out_data=0xFF.
//  4 out_ready=0 for 2 word times -> first word held stable, second dropped,
//    overflow=1; raise out_ready -> first word transferred, overflow stays 1.
//  5 in_valid=0 every other clk -> strobes every 8 clks, words identical to case 2.
//  6 Assert reset mid-word (bit_cnt=5, out_valid=1) -> all outputs 0 next cycle,
//    32-sample skip repeats before next strobe.

Source files
------------

// File: rtl/rx_symbol_slicer.sv
// Symbol slicer: drops the matched-filter start-up transient, decimates by SPS,
// slices each symbol on its sign and packs bits MSB-first into handshaked words.
module rx_symbol_slicer #(
    parameter int DATA_WIDTH = 16,
    parameter int SPS        = 4,
    parameter int SKIP       = 32,
    parameter int PHASE      = 0,
    parameter int WORD_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    output logic                         sym_strobe,
    output logic signed [DATA_WIDTH-1:0] sym_value,
    output logic [WORD_BITS-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow
);

    localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int PH_W   = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int BIT_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SPS - 1);
    localparam logic [PH_W-1:0]   PH_KEEP   = PH_W'(PHASE);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);

    typedef enum logic {ALIGN, SAMPLE} state_t;

    localparam state_t RESET_STATE = (SKIP == 0) ? SAMPLE : ALIGN;

    // Hard decision: non-negative (including zero) maps to 1.
    function automatic logic slice_bit(input logic signed [DATA_WIDTH-1:0] s);
        return ~s[DATA_WIDTH-1];
    endfunction

    state_t                         state_q, state_d;
    logic [SKIP_W-1:0]              skip_cnt_q, skip_cnt_d;
    logic [PH_W-1:0]                phase_cnt_q, phase_cnt_d;
    logic [BIT_W-1:0]               bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-2:0]           shift_q, shift_d;
    logic                           sym_strobe_q, sym_strobe_d;
    logic signed [DATA_WIDTH-1:0]   sym_value_q, sym_value_d;
    logic [WORD_BITS-1:0]           out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic                           overflow_q, overflow_d;

    logic                           slice;
    logic                           word_done;
    logic [WORD_BITS-1:0]           word;

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sym_strobe_d = 1'b0;
        sym_value_d  = sym_value_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        overflow_d   = overflow_q;
        slice        = 1'b0;
        word_done    = 1'b0;
        word         = {shift_q, slice_bit(sample_in)};

        if (in_valid) begin
            case (state_q)
                ALIGN: begin
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d     = SAMPLE;
                        phase_cnt_d = '0;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    slice       = (phase_cnt_q == PH_KEEP);
                    phase_cnt_d = (phase_cnt_q == PH_LAST) ? '0 : phase_cnt_q + 1'b1;
                end
                default: state_d = RESET_STATE;
            endcase
        end

        if (slice) begin
            sym_strobe_d = 1'b1;
            sym_value_d  = sample_in;
            shift_d      = word[WORD_BITS-2:0];
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // Single-entry holding register: a word completing while one is still
        // pending and not being taken is lost, and flagged.
        if (word_done) begin
            if (out_valid_q && !out_ready) begin
                overflow_d = 1'b1;
            end else begin
                out_data_d  = word;
                out_valid_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            skip_cnt_q   <= '0;
            phase_cnt_q  <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            sym_strobe_q <= 1'b0;
            sym_value_q  <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sym_strobe_q <= sym_strobe_d;
            sym_value_q  <= sym_value_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sym_strobe = sym_strobe_q;
    assign sym_value  = sym_value_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rx_symbol_slicer.sv
// Bench for rx_symbol_slicer: directed scenarios plus random traffic, every cycle
// compared against a sample-index/bit-queue reference model.
module tb_rx_symbol_slicer;

    localparam int SKIP = 32;
    localparam int SPS  = 4;
    localparam int PH   = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sym_strobe;
    logic [15:0] sym_value;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;

    rx_symbol_slicer #(
        .DATA_WIDTH(16), .SPS(SPS), .SKIP(SKIP), .PHASE(PH), .WORD_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sample_in(sample_in),
        .sym_strobe(sym_strobe), .sym_value(sym_value), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_strb = 0;

    // Reference model state
    int          m_n = 0;
    bit          m_bits[$];
    logic        m_strobe = 0;
    logic [15:0] m_symval = 0;
    logic [7:0]  m_data = 0;
    logic        m_valid = 0;
    logic        m_ovf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [15:0] s, input logic r, input logic rs);
        logic       done;
        logic [7:0] w;
        int         idx;
        if (rs) begin
            m_n = 0; m_bits.delete(); m_strobe = 0; m_symval = 0;
            m_data = 0; m_valid = 0; m_ovf = 0;
        end else begin
            done = 0; w = 0; m_strobe = 0;
            if (v) begin
                idx = m_n;
                m_n++;
                if (idx >= SKIP && ((idx - SKIP) % SPS) == PH) begin
                    m_strobe = 1;
                    m_symval = s;
                    m_bits.push_back($signed(s) >= 0);
                    if (m_bits.size() == 8) begin
                        for (int i = 0; i < 8; i++) w[7-i] = m_bits[i];
                        m_bits.delete();
                        done = 1;
                    end
                end
            end
            if (done) begin
                if (m_valid && !r) m_ovf = 1;
                else begin m_data = w; m_valid = 1; end
            end else if (m_valid && r) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] s, input logic r, input logic rs);
        in_valid = v; sample_in = s; out_ready = r; reset = rs;
        @(posedge clk);
        model_step(v, s, r, rs);
        #1;
        if (sym_strobe === 1'b1) dut_strb++;
        check("sym_strobe", sym_strobe, m_strobe);
        check("sym_value", sym_value, m_symval);
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("overflow", overflow, m_ovf);
    endtask

    function automatic logic [15:0] pat2(int i);
        if (i < SKIP) return 16'($urandom);
        return ((((i - SKIP) / SPS) % 2) == 0) ? 16'h2000 : 16'hE000;
    endfunction

    initial begin
        int a;
        // 1: constant positive input, reset held 3 cycles
        for (int i = 0; i < 3; i++) cyc(1, 16'h2000, 1, 1);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_strobe", sym_strobe, 0);
        dut_strb = 0;
        for (int i = 0; i < 32; i++) cyc(1, 16'h2000, 1, 0);
        check("skip_no_strobe", dut_strb, 0);
        for (int i = 0; i < 96; i++) cyc(1, 16'h2000, 1, 0);
        check("c1_strobes", dut_strb, 24);
        check("c1_data", out_data, 8'hFF);

        // 2: alternating symbols
        cyc(1, 16'h0, 1, 1);
        for (int i = 0; i < 160; i++) cyc(1, pat2(i), 1, 0);
        check("c2_data", out_data, 8'hAA);

        // 3: zero samples slice high
        cyc(1, 16'h0, 1, 1);
        for (int i = 0; i < 96; i++) cyc(1, 16'h0000, 1, 0);
        check("c3_data", out_data, 8'hFF);

        // 4: consumer stalls for two words
        cyc(1, 16'h0, 0, 1);
        for (int i = 0; i < 96; i++) cyc(1, pat2(i), 0, 0);
        check("c4_held_valid", out_valid, 1);
        check("c4_held_data", out_data, 8'hAA);
        check("c4_ovf", overflow, 1);
        cyc(1, pat2(96), 1, 0);
        check("c4_drained", out_valid, 0);
        check("c4_ovf_sticky", overflow, 1);

        // 5: in_valid every other clock
        cyc(1, 16'h0, 1, 1);
        dut_strb = 0;
        a = 0;
        for (int c = 0; c < 192; c++) begin
            if (c % 2 == 0) begin cyc(1, pat2(a), 1, 0); a++; end
            else cyc(0, 16'($urandom), 1, 0);
        end
        check("c5_strobes", dut_strb, 16);
        check("c5_data", out_data, 8'hAA);

        // 6: reset mid-word with a word pending
        cyc(1, 16'h0, 0, 1);
        for (int i = 0; i < 81; i++) cyc(1, 16'($urandom), 0, 0);
        check("c6_pre_valid", out_valid, 1);
        check("c6_pre_bits", m_bits.size(), 5);
        cyc(1, 16'h7FFF, 1, 1);
        check("c6_rst_valid", out_valid, 0);
        check("c6_rst_data", out_data, 0);
        check("c6_rst_symval", sym_value, 0);
        check("c6_rst_ovf", overflow, 0);
        dut_strb = 0;
        for (int i = 0; i < 32; i++) cyc(1, 16'($urandom), 1, 0);
        check("c6_reskip", dut_strb, 0);
        for (int i = 0; i < 8; i++) cyc(1, 16'($urandom), 1, 0);
        check("c6_resume", dut_strb, 2);

        // Random traffic with random stalls and occasional resets
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(3, 0) != 0), 16'($urandom),
                ($urandom_range(9, 0) < 6), ($urandom_range(499, 0) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
